riscv_prefetch_buffer: RTL
==========================

// Module: riscv_prefetch_buffer
// PURPOSE
//   Instruction prefetch queue between a pipelined instruction memory and the RV64 core fetch stage.
//   Issues sequential 32-bit fetches ahead of the core, buffers in-order responses with their PC,
//   presents a valid/ready instruction stream, and flushes cleanly on a control-flow redirect.
// PARAMETERS
//   DEPTH     4             queue entries; power of 2, >=2; also the cap on entries + in-flight requests
//   RESET_PC  64'h0         first fetch address after reset
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous reset, active-high
//   mem_req_valid   out  1   fetch request valid
//   mem_req_addr    out  64  fetch address (4-byte aligned)
//   mem_req_ready   in   1   memory accepts request this cycle
//   mem_rsp_valid   in   1   response valid; in order, >=1 cycle after accept, no backpressure
//   mem_rsp_data    in   32  response instruction word
//   instr_valid     out  1   head entry valid to core
//   instr           out  32  head instruction word
//   instr_pc        out  64  PC of head instruction
//   instr_ready     in   1   core consumes head this cycle
//   redirect_valid  in   1   flush and restart fetch (branch/jump taken)
//   redirect_pc     in   64  new fetch PC; bits [1:0] ignored (treated as 0)
// BEHAVIOUR
//   Reset (async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, discard=0.
//     Outputs while rst high: mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
//   instr/instr_pc are driven 0 whenever instr_valid=0.
//   Request: mem_req_valid = !redirect_valid && (count + outstanding < DEPTH); mem_req_addr = fetch_pc.
//     req_fire = valid&&ready -> fetch_pc += 4, outstanding++. Addr stable while valid && !ready.
//     Withdrawal of valid is permitted only in a redirect cycle.
//   Response: mem_rsp_valid -> outstanding--. If discard>0: discard--, data dropped.
//     Otherwise push {data, rsp_pc} at the tail and rsp_pc += 4. Credit rule guarantees no overflow;
//     a response arriving while full is an assertion failure.
//   Output: instr_valid = !empty && !redirect_valid; pop on instr_valid && instr_ready.
//     Latency: response at edge N -> instr_valid from cycle N+1 (no bypass). One pop per cycle.
//     Push and pop in the same cycle are both honoured; count unchanged.
//   Redirect (redirect_valid=1 at edge): queue emptied, fetch_pc = rsp_pc = {redirect_pc[63:2],2'b0},
//     discard = outstanding - (mem_rsp_valid ? 1 : 0); a same-cycle response is dropped. No request is
//     issued in that cycle. Redirect has priority over push/pop. Back-to-back redirects: the last one wins;
//     discard recomputed each time from the live outstanding count.
//   Counters: outstanding, discard and count are $clog2(DEPTH+1) bits; fetch_pc and rsp_pc wrap mod 2^64.
//   Reset mid-operation clears all state immediately; the memory is reset on the same rst, so no stale
//     responses arrive after release.
//   Assertions: outstanding never underflows; discard <= outstanding; count + outstanding <= DEPTH.
// TESTING
//   1 RESET_PC=0x8000_0000, ready=1, rsp latency 1, instr_ready=1 -> instr_pc 0x8000_0000,_0004,_0008...
//     with instr matching memory words; first instr_valid 2 cycles after first req_fire.
//   2 DEPTH=4, instr_ready=0 -> exactly 4 requests accepted, then mem_req_valid=0; instr_ready=1
//     for 1 cycle -> exactly 1 new request issued (0x...10).
//   3 2 outstanding + 3 queued, redirect to 0x100 -> queue empty, next 2 responses dropped,
//     next instr_pc=0x100 with word from 0x100.
//   4 Redirect to 0x200 in the same cycle as a response with 1 other outstanding -> discard=1,
//     both old responses dropped; first delivered instr_pc=0x200.
//   5 mem_req_ready low for 3 cycles -> mem_req_addr held at same value; single accept, no skip or duplicate.
//   6 rst asserted mid-stream (queue 3, outstanding 2) -> outputs to reset values asynchronously;
//     after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_prefetch_buffer.sv
// riscv_prefetch_buffer
//   Instruction prefetch queue between a pipelined instruction memory and the
//   fetch stage of an RV64 core. Sequential 32-bit fetches are issued ahead of
//   the core. In-order responses are buffered together with their PC and are
//   presented as a valid/ready stream. A redirect flushes the queue, restarts
//   fetching at the new PC and drops every response still in flight.
//
//   Credit scheme: the sum of queued entries and in-flight requests never
//   exceeds DEPTH. Every accepted response therefore has a free slot.
module riscv_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_S = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    // Fetch side
    logic [63:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic          req_fire;

    // Response side
    logic [63:0]   rsp_pc;
    logic [CW-1:0] discard;
    logic          rsp_drop;
    logic          push;

    // Queue
    logic [31:0]   q_data [DEPTH];
    logic [63:0]   q_pc   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          empty;
    logic          full;
    logic          pop;

    logic [CW:0]   credit_used;
    logic [63:0]   redirect_base;

    assign redirect_base = redirect_pc & ~64'h3;
    assign credit_used   = {1'b0, count} + {1'b0, outstanding};
    assign empty         = (count == '0);
    assign full          = (count == DEPTH_C);

    // Request interface. The rst term keeps the request low while reset is held.
    assign mem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_S);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response is dropped while older, flushed requests are still draining,
    // and also when a redirect happens in the very same cycle.
    assign rsp_drop = mem_rsp_valid && (discard != '0);
    assign push     = mem_rsp_valid && (discard == '0) && !redirect_valid;

    // Output interface; the payload is forced to zero whenever nothing is presented.
    assign instr_valid = !rst && !empty && !redirect_valid;
    assign instr       = instr_valid ? q_data[head] : '0;
    assign instr_pc    = instr_valid ? q_pc[head]   : '0;
    assign pop         = instr_valid && instr_ready;

    // In-flight request count after this cycle's accept and response
    always_comb begin
        outstanding_next = outstanding;
        if (req_fire) begin
            outstanding_next = outstanding_next + ONE_C;
        end
        if (mem_rsp_valid) begin
            outstanding_next = outstanding_next - ONE_C;
        end
    end

    // Queue occupancy after this cycle's push and pop
    always_comb begin
        count_next = count;
        if (push) begin
            count_next = count_next + ONE_C;
        end
        if (pop) begin
            count_next = count_next - ONE_C;
        end
    end

    // Fetch address and in-flight tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
        end
    end

    // Response PC and discard bookkeeping. On a redirect every request still in
    // flight belongs to the old path, except one that completes in this cycle
    // and is dropped right away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_pc  <= RESET_PC;
            discard <= '0;
        end else if (redirect_valid) begin
            rsp_pc  <= redirect_base;
            discard <= outstanding - (mem_rsp_valid ? ONE_C : '0);
        end else begin
            if (push) begin
                rsp_pc <= rsp_pc + 64'd4;
            end
            if (rsp_drop) begin
                discard <= discard - ONE_C;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                tail <= tail + ONE_P;
            end
            if (pop) begin
                head <= head + ONE_P;
            end
        end
    end

    // Queue storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= mem_rsp_data;
            q_pc[tail]   <= rsp_pc;
        end
    end

    // Bookkeeping invariants
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(mem_rsp_valid && (outstanding == '0)));
    a_discard_le_outstanding : assert property (@(posedge clk) disable iff (rst)
        discard <= outstanding);
    a_credit : assert property (@(posedge clk) disable iff (rst)
        credit_used <= DEPTH_S);
    a_no_rsp_when_full : assert property (@(posedge clk) disable iff (rst)
        !(mem_rsp_valid && full));

endmodule
